// File: rtl/sprite_blitter_if.sv
// Bundle of the draw-control, sprite-memory read and frame-buffer write signals
// shared between the composition sequencer side (master) and the blitter (slave).
interface sprite_blitter_if #(
  parameter int BUFFER_DATA_WIDTH = 12,
  parameter int BUFFER_ADDR_WIDTH = 15,
  parameter int SPRITE_ADDR_WIDTH = 8,
  parameter int POS_WIDTH         = 10
);
  logic                                draw_start;
  logic signed [POS_WIDTH-1:0]         pos_x;
  logic signed [POS_WIDTH-1:0]         pos_y;
  logic                                transparent_en;
  logic                                busy;
  logic                                draw_done;
  logic [SPRITE_ADDR_WIDTH-1:0]        sprite_addr;
  logic [BUFFER_DATA_WIDTH-1:0]        sprite_data;
  logic                                write_en;
  logic [BUFFER_ADDR_WIDTH-1:0]        write_addr;
  logic [BUFFER_DATA_WIDTH-1:0]        write_data;

  modport master (
    output draw_start, pos_x, pos_y, transparent_en, sprite_data,
    input  busy, draw_done, sprite_addr, write_en, write_addr, write_data
  );

  modport slave (
    input  draw_start, pos_x, pos_y, transparent_en, sprite_data,
    output busy, draw_done, sprite_addr, write_en, write_addr, write_data
  );
endinterface

// File: rtl/sprite_blitter.sv
// Streams a SPRITE_WIDTH x SPRITE_HEIGHT sprite into the frame buffer at a signed
// position, one pixel per cycle, with edge clipping and optional colour-key skip.
module sprite_blitter #(
  parameter int BUFFER_WIDTH      = 160,
  parameter int BUFFER_HEIGHT     = 120,
  parameter int BUFFER_DATA_WIDTH = 12,
  parameter int BUFFER_ADDR_WIDTH = $clog2(BUFFER_WIDTH*BUFFER_HEIGHT),
  parameter int SPRITE_WIDTH      = 16,
  parameter int SPRITE_HEIGHT     = 16,
  parameter int SPRITE_ADDR_WIDTH = $clog2(SPRITE_WIDTH*SPRITE_HEIGHT),
  parameter int POS_WIDTH         = 10,
  parameter logic [BUFFER_DATA_WIDTH-1:0] TRANSPARENT_COLOR = 12'hF0F
) (
  input logic              clk,
  input logic              rstn,
  sprite_blitter_if.slave  bus
);
  localparam int SXW = (SPRITE_WIDTH  > 1) ? $clog2(SPRITE_WIDTH)  : 1;
  localparam int SYW = (SPRITE_HEIGHT > 1) ? $clog2(SPRITE_HEIGHT) : 1;
  localparam int PW1 = POS_WIDTH + 1;
  localparam logic [SXW-1:0] SX_LAST = SXW'(SPRITE_WIDTH - 1);
  localparam logic [SYW-1:0] SY_LAST = SYW'(SPRITE_HEIGHT - 1);
  localparam logic signed [PW1-1:0] BW_S = PW1'(BUFFER_WIDTH);
  localparam logic signed [PW1-1:0] BH_S = PW1'(BUFFER_HEIGHT);
  localparam logic [BUFFER_ADDR_WIDTH-1:0] BW_A = BUFFER_ADDR_WIDTH'(BUFFER_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                        state_r;
  logic                          busy_r;
  logic                          draw_done_r;
  logic [SPRITE_ADDR_WIDTH-1:0]  addr_r;
  logic [SXW-1:0]                sx_r;
  logic [SYW-1:0]                sy_r;
  logic [SXW-1:0]                sx_d_r;
  logic [SYW-1:0]                sy_d_r;
  logic                          valid_d_r;
  logic signed [POS_WIDTH-1:0]   pos_x_r;
  logic signed [POS_WIDTH-1:0]   pos_y_r;
  logic                          transparent_en_r;

  logic                          last_pix_s;
  logic signed [PW1-1:0]         px_ext_s, py_ext_s, sx_ext_s, sy_ext_s, tx_s, ty_s;
  logic                          in_x_s, in_y_s, key_hit_s;
  logic [BUFFER_ADDR_WIDTH-1:0]  lin_addr_s;
  logic                          write_en_s;
  logic [BUFFER_ADDR_WIDTH-1:0]  write_addr_s;
  logic [BUFFER_DATA_WIDTH-1:0]  write_data_s;

  assign last_pix_s = (sx_r == SX_LAST) && (sy_r == SY_LAST);

  // Control FSM: launch, raster counters, read-stage pipeline and done pulse
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r          <= ST_IDLE;
      busy_r           <= 1'b0;
      draw_done_r      <= 1'b0;
      addr_r           <= '0;
      sx_r             <= '0;
      sy_r             <= '0;
      sx_d_r           <= '0;
      sy_d_r           <= '0;
      valid_d_r        <= 1'b0;
      pos_x_r          <= '0;
      pos_y_r          <= '0;
      transparent_en_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          valid_d_r   <= 1'b0;
          draw_done_r <= 1'b0;
          if (bus.draw_start) begin
            pos_x_r          <= bus.pos_x;
            pos_y_r          <= bus.pos_y;
            transparent_en_r <= bus.transparent_en;
            sx_r             <= '0;
            sy_r             <= '0;
            addr_r           <= '0;
            busy_r           <= 1'b1;
            state_r          <= ST_READ;
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_READ: begin
          sx_d_r    <= sx_r;
          sy_d_r    <= sy_r;
          valid_d_r <= 1'b1;
          // addr_r tracks sy*SPRITE_WIDTH+sx as a running raster index
          if (last_pix_s) begin
            sx_r    <= '0;
            sy_r    <= '0;
            addr_r  <= '0;
            state_r <= ST_FLUSH;
          end else if (sx_r == SX_LAST) begin
            sx_r   <= '0;
            sy_r   <= sy_r + SYW'(1);
            addr_r <= addr_r + SPRITE_ADDR_WIDTH'(1);
          end else begin
            sx_r   <= sx_r + SXW'(1);
            addr_r <= addr_r + SPRITE_ADDR_WIDTH'(1);
          end
        end
        ST_FLUSH: begin
          valid_d_r   <= 1'b0;
          draw_done_r <= 1'b1;
          state_r     <= ST_DONE;
        end
        ST_DONE: begin
          draw_done_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= ST_IDLE;
        end
        default: begin
          valid_d_r   <= 1'b0;
          draw_done_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign px_ext_s  = {pos_x_r[POS_WIDTH-1], pos_x_r};
  assign py_ext_s  = {pos_y_r[POS_WIDTH-1], pos_y_r};
  assign sx_ext_s  = {{(PW1-SXW){1'b0}}, sx_d_r};
  assign sy_ext_s  = {{(PW1-SYW){1'b0}}, sy_d_r};
  assign tx_s      = px_ext_s + sx_ext_s;
  assign ty_s      = py_ext_s + sy_ext_s;
  assign in_x_s    = !tx_s[PW1-1] && (tx_s < BW_S);
  assign in_y_s    = !ty_s[PW1-1] && (ty_s < BH_S);
  assign key_hit_s = transparent_en_r && (bus.sprite_data == TRANSPARENT_COLOR);
  assign lin_addr_s = BUFFER_ADDR_WIDTH'($unsigned(ty_s)) * BW_A
                    + BUFFER_ADDR_WIDTH'($unsigned(tx_s));

  // Write stage: clip/key decision on the pixel returned by the sprite memory
  always_comb begin
    write_en_s   = 1'b0;
    write_addr_s = '0;
    write_data_s = '0;
    if (valid_d_r) begin
      write_en_s   = in_x_s && in_y_s && !key_hit_s;
      write_addr_s = lin_addr_s;
      write_data_s = bus.sprite_data;
    end else begin
      write_en_s   = 1'b0;
    end
  end

  assign bus.busy        = busy_r;
  assign bus.draw_done   = draw_done_r;
  assign bus.sprite_addr = addr_r;
  assign bus.write_en    = write_en_s;
  assign bus.write_addr  = write_addr_s;
  assign bus.write_data  = write_data_s;
endmodule

// File: tb/tb_sprite_blitter.sv
// Scoreboard bench for sprite_blitter with a 4x4 sprite: stimulus pushes expected
// writes/done cycles, a negedge monitor pops and compares them.
module tb_sprite_blitter;
  localparam int SW = 4;
  localparam int SH = 4;
  localparam int NP = SW * SH;
  localparam int BW = 160;
  localparam int BH = 120;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  sprite_blitter_if #(
    .BUFFER_DATA_WIDTH(12), .BUFFER_ADDR_WIDTH(15),
    .SPRITE_ADDR_WIDTH(4),  .POS_WIDTH(10)
  ) bus ();

  sprite_blitter #(
    .SPRITE_WIDTH(SW), .SPRITE_HEIGHT(SH)
  ) dut (
    .clk(clk), .rstn(rstn), .bus(bus)
  );

  wr_t        exp_q[$];
  int         done_q[$];
  int         obs_addr[$];
  int         obs_data[$];
  logic [11:0] mem [NP];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read sprite memory model
  always @(posedge clk) bus.sprite_data <= mem[bus.sprite_addr];

  // Monitor: every write and every draw_done must match the head of its queue
  always @(negedge clk) begin : monitor
    wr_t e;
    int  dc;
    if (bus.write_en) begin
      obs_addr.push_back(int'(bus.write_addr));
      obs_data.push_back(int'(bus.write_data));
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected: got addr %0d data %h cycle %0d, required no write",
                 bus.write_addr, bus.write_data, cyc);
      end else begin
        e = exp_q.pop_front();
        if (e.addr != int'(bus.write_addr) || e.data != int'(bus.write_data) || e.cyc != cyc) begin
          errors++;
          $display("FAIL write: got addr %0d data %h cycle %0d, required addr %0d data %h cycle %0d",
                   bus.write_addr, bus.write_data, cyc, e.addr, e.data, e.cyc);
        end
      end
    end
    if (bus.draw_done) begin
      checks++;
      if (done_q.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected: got draw_done at cycle %0d, required none", cyc);
      end else begin
        dc = done_q.pop_front();
        if (dc != cyc) begin
          errors++;
          $display("FAIL done_cycle: got cycle %0d, required cycle %0d", cyc, dc);
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  function automatic int obs_at(input int i);
    if (i >= 0 && i < obs_addr.size()) return obs_addr[i];
    else return -1;
  endfunction

  function automatic int obsd_at(input int i);
    if (i >= 0 && i < obs_data.size()) return obs_data[i];
    else return -1;
  endfunction

  function automatic bit obs_has(input int a);
    foreach (obs_addr[i]) if (obs_addr[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  // Reference: pixel i sits at (x+i%SW, y+i/SW) and is written in cycle T(i+2)
  task automatic push_model(input int x, input int y, input bit te, input int c0, input int npix);
    wr_t w;
    for (int i = 0; i < npix; i++) begin
      int tx, ty;
      tx = x + i % SW;
      ty = y + i / SW;
      if (tx >= 0 && tx < BW && ty >= 0 && ty < BH && !(te && mem[i] == 12'hF0F)) begin
        w.addr = ty * BW + tx;
        w.data = int'(mem[i]);
        w.cyc  = c0 + i + 1;
        exp_q.push_back(w);
      end
    end
  endtask

  task automatic run_draw(input int x, input int y, input bit te,
                          input int pulse_k, input int abort_k);
    int c0;
    obs_addr.delete();
    obs_data.delete();
    @(negedge clk);
    bus.draw_start     = 1'b1;
    bus.pos_x          = 10'(x);
    bus.pos_y          = 10'(y);
    bus.transparent_en = te;
    @(posedge clk);
    #1 c0 = cyc;
    if (abort_k > 0) begin
      push_model(x, y, te, c0, abort_k - 1);
    end else begin
      push_model(x, y, te, c0, NP);
      done_q.push_back(c0 + NP + 1);
    end
    @(negedge clk);
    bus.draw_start     = 1'b0;
    bus.pos_x          = 10'(x + 7);
    bus.pos_y          = 10'(y - 3);
    bus.transparent_en = ~te;
    for (int k = 1; k <= NP + 3; k++) begin
      if (k > 1) @(negedge clk);
      check($sformatf("busy_T%0d", k), int'(bus.busy), (k <= NP + 2) ? 1 : 0);
      if (pulse_k > 0 && k == pulse_k) begin
        bus.draw_start = 1'b1;
        bus.pos_x      = 10'(50);
      end else if (pulse_k > 0 && k == pulse_k + 1) begin
        bus.draw_start = 1'b0;
      end
      if (abort_k > 0 && k == abort_k) begin
        #1 rstn = 1'b0;
        #1;
        check("abort_write_en", int'(bus.write_en), 0);
        check("abort_busy", int'(bus.busy), 0);
        check("abort_sprite_addr", int'(bus.sprite_addr), 0);
        check("abort_write_addr", int'(bus.write_addr), 0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        break;
      end
    end
    check("scoreboard_drained", exp_q.size() + done_q.size(), 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int c0;
    for (int i = 0; i < NP; i++) mem[i] = 12'(12'h100 + i);
    bus.draw_start     = 1'b0;
    bus.pos_x          = '0;
    bus.pos_y          = '0;
    bus.transparent_en = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_draw_done", int'(bus.draw_done), 0);
    check("rst_sprite_addr", int'(bus.sprite_addr), 0);
    check("rst_write_en", int'(bus.write_en), 0);
    check("rst_write_addr", int'(bus.write_addr), 0);
    check("rst_write_data", int'(bus.write_data), 0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // On-screen draw
    run_draw(10, 20, 1'b0, 0, 0);
    check("onscreen_count", obs_addr.size(), 16);
    check("onscreen_first_addr", obs_at(0), 3210);
    check("onscreen_first_data", obsd_at(0), 12'h100);
    check("onscreen_last_addr", obs_at(15), 3693);
    check("onscreen_last_data", obsd_at(15), 12'h10F);

    // Colour key on pixel 5
    mem[5] = 12'hF0F;
    run_draw(10, 20, 1'b1, 0, 0);
    check("key_on_count", obs_addr.size(), 15);
    check("key_on_no_3371", int'(obs_has(3371)), 0);
    run_draw(10, 20, 1'b0, 0, 0);
    check("key_off_count", obs_addr.size(), 16);
    check("key_off_has_3371", int'(obs_has(3371)), 1);
    mem[5] = 12'h105;

    // Corner clipping
    run_draw(-2, -2, 1'b0, 0, 0);
    check("clip_tl_count", obs_addr.size(), 4);
    check("clip_tl_a0", obs_at(0), 0);
    check("clip_tl_a1", obs_at(1), 1);
    check("clip_tl_a2", obs_at(2), 160);
    check("clip_tl_a3", obs_at(3), 161);
    check("clip_tl_d0", obsd_at(0), 12'h10A);
    check("clip_tl_d1", obsd_at(1), 12'h10B);
    check("clip_tl_d2", obsd_at(2), 12'h10E);
    check("clip_tl_d3", obsd_at(3), 12'h10F);
    run_draw(158, 118, 1'b0, 0, 0);
    check("clip_br_count", obs_addr.size(), 4);
    check("clip_br_a0", obs_at(0), 19038);
    check("clip_br_a1", obs_at(1), 19039);
    check("clip_br_a2", obs_at(2), 19198);
    check("clip_br_a3", obs_at(3), 19199);

    // Fully off-screen
    run_draw(200, 0, 1'b0, 0, 0);
    check("offscreen_right_count", obs_addr.size(), 0);
    run_draw(-4, 50, 1'b0, 0, 0);
    check("offscreen_left_count", obs_addr.size(), 0);

    // Start pulse with a new position during the draw is ignored
    run_draw(30, 40, 1'b0, 5, 0);
    check("midpulse_count", obs_addr.size(), 16);
    check("midpulse_first_addr", obs_at(0), 40 * 160 + 30);

    // draw_start held high: second draw launches from the single IDLE cycle
    obs_addr.delete();
    obs_data.delete();
    @(negedge clk);
    bus.draw_start     = 1'b1;
    bus.pos_x          = 10'(5);
    bus.pos_y          = 10'(6);
    bus.transparent_en = 1'b0;
    @(posedge clk);
    #1 c0 = cyc;
    push_model(5, 6, 1'b0, c0, NP);
    done_q.push_back(c0 + NP + 1);
    push_model(5, 6, 1'b0, c0 + NP + 3, NP);
    done_q.push_back(c0 + 2 * NP + 4);
    for (int k = 1; k <= 2 * NP + 6; k++) begin
      @(negedge clk);
      check($sformatf("b2b_busy_T%0d", k), int'(bus.busy),
            (k == NP + 3 || k == 2 * NP + 6) ? 0 : 1);
      if (k == NP + 4) bus.draw_start = 1'b0;
    end
    check("b2b_count", obs_addr.size(), 32);
    check("b2b_drained", exp_q.size() + done_q.size(), 0);

    // Reset during cycle T8, then a clean draw
    run_draw(10, 20, 1'b0, 0, 8);
    check("abort_count", obs_addr.size(), 7);
    repeat (2) @(negedge clk);
    run_draw(10, 20, 1'b0, 0, 0);
    check("post_reset_count", obs_addr.size(), 16);
    check("post_reset_last_addr", obs_at(15), 3693);

    repeat (4) @(negedge clk);
    check("final_drained", exp_q.size() + done_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
